// File: rtl/dcache_ctrl_if.sv
// Bus bundle between the CPU pipeline, the data cache controller and main memory.
// The slave modport is the cache's view; master is the view of whatever drives
// the CPU requests and plays the memory.
interface dcache_ctrl_if;
    logic         p1_req_i;
    logic         p1_write_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i;
    logic [255:0] mem_data_i;

    modport slave (
        input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_ack_i, mem_data_i,
        output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_ack_i, mem_data_i,
        input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 32 lines of 32-byte blocks; hits complete with no added latency, misses
// write back a dirty victim (WB), read the new block (RD), install it (FILL)
// and then let the held request retry in IDLE, where it hits.
module dcache_ctrl (
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WB, RD, FILL} state_t;

    state_t        state_q, state_d;

    logic [31:0]   valid_q;
    logic [31:0]   dirty_q;
    logic [21:0]   tag_q  [32];
    logic [31:0]   data_q [32][8];

    logic [4:0]    missIdx_q;
    logic [21:0]   missTag_q;
    logic [255:0]  fillBlk_q;

    logic [21:0]   reqTag;
    logic [4:0]    reqIdx;
    logic [2:0]    reqWord;
    logic          hit;
    logic          miss;
    logic          hitStore;
    logic [255:0]  victimBlk;
    logic          unused_addr_lsb;

    assign reqTag          = bus.p1_addr_i[31:10];
    assign reqIdx          = bus.p1_addr_i[9:5];
    assign reqWord         = bus.p1_addr_i[4:2];
    assign unused_addr_lsb = ^bus.p1_addr_i[1:0];

    assign hit      = bus.p1_req_i & valid_q[reqIdx] & (tag_q[reqIdx] == reqTag);
    assign miss     = (state_q == IDLE) & bus.p1_req_i & ~hit;
    assign hitStore = (state_q == IDLE) & hit & bus.p1_write_i;

    // State register; reset abandons any memory transaction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: miss picks WB for a dirty victim, memory acks advance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = (valid_q[reqIdx] & dirty_q[reqIdx]) ? WB : RD;
                end
            end
            WB: begin
                if (bus.mem_ack_i) begin
                    state_d = RD;
                end
            end
            RD: begin
                if (bus.mem_ack_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line status bits and the latched miss address; only these need reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q   <= '0;
            dirty_q   <= '0;
            missIdx_q <= '0;
            missTag_q <= '0;
        end else begin
            if (miss) begin
                missIdx_q <= reqIdx;
                missTag_q <= reqTag;
            end
            if (hitStore) begin
                dirty_q[reqIdx] <= 1'b1;
            end
            if (state_q == FILL) begin
                valid_q[missIdx_q] <= 1'b1;
                dirty_q[missIdx_q] <= 1'b0;
            end
        end
    end

    // Tag/data arrays and the fill buffer; contents are don't-care while invalid.
    always_ff @(posedge clk_i) begin
        if (hitStore) begin
            data_q[reqIdx][reqWord] <= bus.p1_data_i;
        end else if (state_q == FILL) begin
            for (int w = 0; w < 8; w++) begin
                data_q[missIdx_q][w[2:0]] <= fillBlk_q[w*32 +: 32];
            end
        end
        if (state_q == FILL) begin
            tag_q[missIdx_q] <= missTag_q;
        end
        if ((state_q == RD) && bus.mem_ack_i) begin
            fillBlk_q <= bus.mem_data_i;
        end
    end

    // Flatten the victim line into a memory block, word 0 in the low bits.
    always_comb begin
        victimBlk = '0;
        for (int w = 0; w < 8; w++) begin
            victimBlk[w*32 +: 32] = data_q[missIdx_q][w[2:0]];
        end
    end

    // Output decode: everything is zero unless the current state makes it meaningful.
    always_comb begin
        bus.p1_data_o    = '0;
        bus.p1_stall_o   = 1'b0;
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_data_o   = '0;
        case (state_q)
            IDLE: begin
                bus.p1_stall_o = miss;
                if (hit && !bus.p1_write_i) begin
                    bus.p1_data_o = data_q[reqIdx][reqWord];
                end
            end
            WB: begin
                bus.p1_stall_o   = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = {tag_q[missIdx_q], missIdx_q, 5'b0};
                bus.mem_data_o   = victimBlk;
            end
            RD: begin
                bus.p1_stall_o   = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o   = {missTag_q, missIdx_q, 5'b0};
            end
            FILL: begin
                bus.p1_stall_o = 1'b1;
            end
            default: begin
                bus.p1_stall_o = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl. The bench plays the memory:
// block at address A holds word w = 0x1000_0000 + A + w.
module tb_dcache_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   testCount = 0;
    int   failCount = 0;

    dcache_ctrl_if bus ();

    dcache_ctrl dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus.p1_req_i   = req;
        bus.p1_write_i = wr;
        bus.p1_addr_i  = addr;
        bus.p1_data_i  = wdata;
    endtask

    function automatic logic [255:0] memBlock(input logic [31:0] blockAddr);
        logic [255:0] blk;
        for (int w = 0; w < 8; w++) begin
            blk[w*32 +: 32] = 32'h1000_0000 + blockAddr + w;
        end
        return blk;
    endfunction

    // Access that hits: no stall, load data available in the same cycle.
    task automatic hitAccess(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] expData);
        applyStimulus(1'b1, wr, addr, wdata);
        #1;
        checkOutput({tag, "_stall"}, bus.p1_stall_o, 1'b0);
        if (!wr) begin
            checkOutput({tag, "_data"}, bus.p1_data_o, expData);
        end
        @(negedge clk);
    endtask

    // Access that misses: answers WB/RD with the given latencies, counts stall cycles.
    task automatic accessMiss(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic expWb, input logic [31:0] wbAddr, input logic [255:0] wbData, input int wbLat,
                              input logic [31:0] rdAddr, input int rdLat, input int dropAt,
                              input int expStall, input logic [31:0] expData);
        int   stallCnt = 0;
        int   phaseCnt = 0;
        logic sawWb    = 1'b0;
        logic sawRd    = 1'b0;
        logic done     = 1'b0;
        applyStimulus(1'b1, wr, addr, wdata);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            bus.mem_ack_i  = 1'b0;
            bus.mem_data_i = '0;
            if (!bus.p1_stall_o) begin
                done = 1'b1;
            end else begin
                stallCnt++;
                if (dropAt != 0 && stallCnt == dropAt) begin
                    bus.p1_req_i = 1'b0;
                end
                if (bus.mem_enable_o) begin
                    phaseCnt++;
                    if (bus.mem_write_o) begin
                        if (phaseCnt == 1) begin
                            sawWb = 1'b1;
                            checkOutput({tag, "_wb_addr"}, bus.mem_addr_o, wbAddr);
                            checkOutput({tag, "_wb_data"}, bus.mem_data_o, wbData);
                        end
                        if (phaseCnt >= wbLat) begin
                            bus.mem_ack_i = 1'b1;
                            phaseCnt      = 0;
                        end
                    end else begin
                        if (phaseCnt == 1) begin
                            sawRd = 1'b1;
                            checkOutput({tag, "_rd_addr"}, bus.mem_addr_o, rdAddr);
                        end
                        if (phaseCnt >= rdLat) begin
                            bus.mem_ack_i  = 1'b1;
                            bus.mem_data_i = memBlock(rdAddr);
                            phaseCnt       = 0;
                        end
                    end
                end
                @(negedge clk);
            end
        end
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        checkOutput({tag, "_finished"}, done, 1'b1);
        checkOutput({tag, "_stall_cycles"}, stallCnt, expStall);
        checkOutput({tag, "_saw_wb"}, sawWb, expWb);
        checkOutput({tag, "_saw_rd"}, sawRd, 1'b1);
        checkOutput({tag, "_mem_idle"}, bus.mem_enable_o, 1'b0);
        if (!wr && dropAt == 0) begin
            checkOutput({tag, "_data"}, bus.p1_data_o, expData);
        end
        @(negedge clk);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        logic [255:0] blk;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_stall", bus.p1_stall_o, 1'b0);
        checkOutput("reset_mem_enable", bus.mem_enable_o, 1'b0);
        checkOutput("reset_mem_write", bus.mem_write_o, 1'b0);
        checkOutput("reset_p1_data", bus.p1_data_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            bus.mem_ack_i  = 1'($urandom_range(0, 1));
            bus.mem_data_i = {8{$urandom}};
            #1;
            checkOutput("idle_stall", bus.p1_stall_o, 1'b0);
            checkOutput("idle_mem_enable", bus.mem_enable_o, 1'b0);
            @(negedge clk);
        end
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;

        accessMiss("cold_load", 1'b0, 32'h0000_0404, 32'h0, 1'b0, 32'h0, '0, 0,
                   32'h0000_0400, 3, 0, 5, 32'h1000_0401);
        hitAccess("store_hit", 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0);
        hitAccess("load_back", 1'b0, 32'h0000_0404, 32'h0, 32'hDEAD_BEEF);

        blk         = memBlock(32'h0000_0400);
        blk[63:32]  = 32'hDEAD_BEEF;
        accessMiss("dirty_load", 1'b0, 32'h0000_0804, 32'h0, 1'b1, 32'h0000_0400, blk, 2,
                   32'h0000_0800, 1, 0, 5, 32'h1000_0801);

        accessMiss("store_miss", 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1'b0, 32'h0, '0, 0,
                   32'h0000_1000, 2, 0, 4, 32'h0);
        blk        = memBlock(32'h0000_1000);
        blk[31:0]  = 32'hCAFE_F00D;
        for (int w = 0; w < 8; w++) begin
            hitAccess($sformatf("fill_word%0d", w), 1'b0, 32'h0000_1000 + 32'(w * 4), 32'h0, blk[w*32 +: 32]);
        end
        accessMiss("evict_store", 1'b0, 32'h0000_2008, 32'h0, 1'b1, 32'h0000_1000, blk, 1,
                   32'h0000_2000, 1, 0, 4, 32'h1000_2002);

        accessMiss("drop_req", 1'b1, 32'h0000_0C04, 32'h5555_5555, 1'b0, 32'h0, '0, 0,
                   32'h0000_0C00, 2, 2, 4, 32'h0);
        hitAccess("drop_load", 1'b0, 32'h0000_0C04, 32'h0, 32'h1000_0C01);

        applyStimulus(1'b1, 1'b0, 32'h0000_3004, 32'h0);
        #1;
        checkOutput("rst_miss_stall", bus.p1_stall_o, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("rst_rd_enable", bus.mem_enable_o, 1'b1);
        checkOutput("rst_rd_addr", bus.mem_addr_o, 32'h0000_3000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_enable_drop", bus.mem_enable_o, 1'b0);
        checkOutput("rst_write_low", bus.mem_write_o, 1'b0);
        checkOutput("rst_addr_zero", bus.mem_addr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        accessMiss("post_rst_load", 1'b0, 32'h0000_3004, 32'h0, 1'b0, 32'h0, '0, 0,
                   32'h0000_3000, 1, 0, 3, 32'h1000_3001);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
